// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan register bank and its shift sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    function automatic int chain_len(input int width, input int chains);
        // Guard against a zero divisor so the elaboration check can report it cleanly.
        return (chains < 1) ? width : width / chains;
    endfunction

    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/scan_shift_ctrl.sv
// Auto-shift sequencer: accepts a request in IDLE, counts SLEN shift cycles down, then pulses done.
//
// state | meaning
// IDLE  | waiting for a shift request
// SHIFT | shifting all chains, one bit per cycle, counter holds shifts remaining
// DONE  | one-cycle completion pulse, requests ignored
module scan_shift_ctrl
    import scan_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_b_i,
    input  logic          sreq_i,
    input  logic [CW-1:0] slen_i,
    output logic          shift_en_o,
    output logic          sbusy_o,
    output logic          sdone_o
);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sreq_i) begin
                    if (slen_i != '0) begin
                        state_d = SHIFT;
                        cnt_d   = slen_i;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                // The edge seen with one shift left performs that last shift.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign shift_en_o = (state_q == SHIFT);
    assign sbusy_o    = (state_q == SHIFT);
    assign sdone_o    = (state_q == DONE);

endmodule

// File: rtl/scan_dff_bank.sv
// Bank of muxed-scan flops split into CHAINS equal chains, with manual and counted auto-shift.
module scan_dff_bank
    import scan_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 1,
    localparam int L     = chain_len(WIDTH, CHAINS),
    localparam int CW    = cnt_width(L)
) (
    input  logic              CK,
    input  logic              RB,
    input  logic [WIDTH-1:0]  D,
    input  logic              EN,
    input  logic              SEL,
    input  logic [CHAINS-1:0] TD,
    input  logic              SREQ,
    input  logic [CW-1:0]     SLEN,
    output logic [WIDTH-1:0]  Q,
    output logic [CHAINS-1:0] TQ,
    output logic              SBUSY,
    output logic              SDONE
);

    if (CHAINS < 1 || (WIDTH % CHAINS) != 0) begin : g_bad_cfg
        $error("scan_dff_bank: CHAINS must be >= 1 and divide WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_en;

    scan_shift_ctrl #(
        .CW (CW)
    ) u_ctrl (
        .clk_i      (CK),
        .rst_b_i    (RB),
        .sreq_i     (SREQ),
        .slen_i     (SLEN),
        .shift_en_o (shift_en),
        .sbusy_o    (SBUSY),
        .sdone_o    (SDONE)
    );

    // An auto-shift in progress overrides both manual shift and functional load.
    always_comb begin
        q_d = q_q;
        if (shift_en || SEL) begin
            for (int c = 0; c < CHAINS; c++) begin
                q_d[c*L] = TD[c];
                for (int k = 1; k < L; k++) begin
                    q_d[c*L + k] = q_q[c*L + k - 1];
                end
            end
        end else if (EN) begin
            q_d = D;
        end
    end

    always_ff @(posedge CK) begin
        if (!RB) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_tq
        assign TQ[c] = q_q[c*L + L - 1];
    end

    assign Q = q_q;

endmodule

// File: tb/tb_scan_dff_bank.sv
// Scoreboarded bench: a chain-level arithmetic model predicts every cycle; a monitor checks the DUTs.
module tb_scan_dff_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-chain DUT (WIDTH=8, L=4)
    logic       rb, en, sel, sreq;
    logic [7:0] d;
    logic [1:0] td;
    logic [2:0] slen;
    logic [7:0] q;
    logic [1:0] tq;
    logic       sbusy, sdone;

    // Single-chain DUT (WIDTH=8, L=8)
    logic       rb1, en1, sel1, sreq1;
    logic [7:0] d1;
    logic [0:0] td1;
    logic [3:0] slen1;
    logic [7:0] q1;
    logic [0:0] tq1;
    logic       sbusy1, sdone1;

    scan_dff_bank #(.WIDTH(8), .CHAINS(2)) u_dut (
        .CK(clk), .RB(rb), .D(d), .EN(en), .SEL(sel), .TD(td), .SREQ(sreq), .SLEN(slen),
        .Q(q), .TQ(tq), .SBUSY(sbusy), .SDONE(sdone)
    );

    scan_dff_bank #(.WIDTH(8), .CHAINS(1)) u_dut1 (
        .CK(clk), .RB(rb1), .D(d1), .EN(en1), .SEL(sel1), .TD(td1), .SREQ(sreq1), .SLEN(slen1),
        .Q(q1), .TQ(tq1), .SBUSY(sbusy1), .SDONE(sdone1)
    );

    typedef struct packed {
        logic [7:0] q;
        logic [1:0] tq;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    obs_t exp1_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: register value, shifts still owed, and a pending done pulse.
    logic [7:0] m_q;
    int         m_rem;
    bit         m_done;

    function automatic logic [7:0] shift_chains(input logic [7:0] v, input logic [1:0] t);
        logic [7:0] r;
        int         ch;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            ch = (int'(v) >> (4 * c)) & 15;
            ch = ((ch * 2) + int'(t[c])) % 16;
            r  = r | 8'(ch << (4 * c));
        end
        return r;
    endfunction

    task automatic tick();
        obs_t e;
        bit   nd;
        assert (slen <= 3'd4) else $error("FAIL slen_range slen=%0d limit=4", slen);
        assert (slen1 <= 4'd8) else $error("FAIL slen1_range slen=%0d limit=8", slen1);
        if (!rb) begin
            m_q = '0; m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            m_q    = shift_chains(m_q, td);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
        end else begin
            nd = 0;
            if (!m_done && sreq) begin
                if (slen != 0) m_rem = int'(slen);
                else           nd    = 1;
            end
            m_done = nd;
            if (sel)     m_q = shift_chains(m_q, td);
            else if (en) m_q = d;
        end
        e = {m_q, m_q[7], m_q[3], (m_rem > 0), m_done};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] v, input logic t, input logic b, input logic dn);
        exp1_q.push_back({v, 1'b0, t, b, dn});
    endtask

    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {q, tq, sbusy, sdone};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL chain2 t=%0t got q=%h tq=%b busy=%b done=%b want q=%h tq=%b busy=%b done=%b",
                             $time, a.q, a.tq, a.busy, a.done, e.q, e.tq, e.busy, e.done);
                end
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                a = {q1, 1'b0, tq1, sbusy1, sdone1};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL chain1 t=%0t got q=%h tq=%b busy=%b done=%b want q=%h tq=%b busy=%b done=%b",
                             $time, a.q, a.tq[0], a.busy, a.done, e.q, e.tq[0], e.busy, e.done);
                end
            end
        end
    end

    initial begin
        bit tq_seq [8];
        logic [7:0] v;
        tq_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        m_q = '0; m_rem = 0; m_done = 0;
        rb = 0; en = 0; sel = 0; sreq = 0; d = '0; td = '0; slen = '0;
        rb1 = 0; en1 = 0; sel1 = 0; sreq1 = 0; d1 = '0; td1 = '0; slen1 = '0;

        tick();
        rb = 1;
        // Functional load and hold
        en = 1; d = 8'hA5; tick();
        en = 0; d = 8'hFF; repeat (3) tick();
        // Manual shift beats load
        sel = 1; en = 1; d = 8'h00; td = 2'b01; tick();
        td = 2'b11; tick();
        sel = 0; en = 0;
        // Auto-shift of 3 with interference while busy
        rb = 0; tick(); rb = 1;
        sreq = 1; slen = 3; td = 2'b11; tick();
        sel = 1; en = 1; d = 8'h55; slen = 1; repeat (3) tick();
        sel = 0; en = 0; sreq = 0; tick();
        tick();
        // Zero-length request
        sreq = 1; slen = 0; tick();
        sreq = 0; repeat (2) tick();
        // Reset mid-shift aborts without a done pulse
        sreq = 1; slen = 4; td = 2'b10; tick();
        sreq = 0; tick();
        rb = 0; tick();
        rb = 1; repeat (3) tick();
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rb   = ($urandom_range(0, 39) != 0);
            sel  = ($urandom_range(0, 4) == 0);
            en   = ($urandom_range(0, 1) == 1);
            d    = 8'($urandom);
            td   = 2'($urandom);
            sreq = ($urandom_range(0, 3) == 0);
            slen = 3'($urandom_range(0, 4));
            tick();
        end
        rb = 1; sel = 0; en = 0; sreq = 0;
        // Single chain, full-length auto-shift
        push1(8'h00, 1'b0, 1'b0, 1'b0); tick();
        rb1 = 1; en1 = 1; d1 = 8'h81;
        push1(8'h81, 1'b1, 1'b0, 1'b0); tick();
        en1 = 0; sreq1 = 1; slen1 = 4'd8; td1 = 1'b0;
        push1(8'h81, tq_seq[0], 1'b1, 1'b0); tick();
        sreq1 = 0;
        v = 8'h81;
        for (int k = 1; k <= 8; k++) begin
            v = 8'(v << 1);
            push1(v, (k < 8) ? tq_seq[k] : 1'b0, (k < 8), (k == 8));
            tick();
        end
        push1(8'h00, 1'b0, 1'b0, 1'b0); tick();

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", exp_q.size(), exp1_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
